// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction FIFO feeding an RV base decoder whose
// result is held in a registered valid/ready output slot.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   flush              synchronous discard of FIFO contents and output slot
//   in_valid/in_ready  fetch handshake; in_ready = room in the FIFO
//   in_instr, in_pc    raw instruction and its PC
//   out_valid/ready    execute handshake for the decoded slot
//   out_pc, out_rs1/rs2/rd, out_imm          operand fields
//   out_op, out_alufunc, out_branch, out_wbsel, out_memrw, out_memsize,
//   out_regwrite, out_sela, out_selb, out_pcsrc, out_pctarget,
//   out_wordop, out_illegal                  decoded control fields
module decode_queue #(
   parameter int XLEN     = 64,
   parameter int DEPTH    = 4,
   parameter bit ENABLE_W = 1'b1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_op,
   output logic [3:0]      out_alufunc,
   output logic [2:0]      out_branch,
   output logic [1:0]      out_wbsel,
   output logic [1:0]      out_memrw,
   output logic [2:0]      out_memsize,
   output logic            out_regwrite,
   output logic            out_sela,
   output logic            out_selb,
   output logic            out_pcsrc,
   output logic            out_pctarget,
   output logic            out_wordop,
   output logic            out_illegal
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   // Word ops only exist on RV64.
   localparam bit W_EN = ENABLE_W && (XLEN == 64);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011, OPC_OP     = 7'b0110011,
                          OPC_OP_IMMW = 7'b0011011, OPC_OPW   = 7'b0111011,
                          OPC_JAL    = 7'b1101111, OPC_JALR   = 7'b1100111,
                          OPC_BRANCH = 7'b1100011, OPC_AUIPC  = 7'b0010111,
                          OPC_LUI    = 7'b0110111, OPC_LOAD   = 7'b0000011,
                          OPC_STORE  = 7'b0100011;

   localparam logic [2:0] OP_I = 3'd1, OP_R = 3'd2, OP_S = 3'd3,
                          OP_B = 3'd4, OP_U = 3'd5, OP_J = 3'd6;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR   = 4'd3,
                          A_XOR = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_SRA  = 4'd7,
                          A_SLT = 4'd8, A_SLTU = 4'd9;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      op;
      logic [3:0]      alufunc;
      logic [2:0]      branch;
      logic [1:0]      wbsel;
      logic [1:0]      memrw;
      logic [2:0]      memsize;
      logic            regwrite;
      logic            sela;
      logic            selb;
      logic            pcsrc;
      logic            pctarget;
      logic            wordop;
      logic            illegal;
   } dec_t;

   function automatic logic [3:0] alu_of_f3(input logic [2:0] f3);
      case (f3)
         3'b000:  return A_ADD;
         3'b001:  return A_SLL;
         3'b010:  return A_SLT;
         3'b011:  return A_SLTU;
         3'b100:  return A_XOR;
         3'b101:  return A_SRL;
         3'b110:  return A_OR;
         default: return A_AND;
      endcase
   endfunction

   logic [31:0]     instr_mem [DEPTH];
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            push, load;

   assign in_ready = resetn && (count < DEPTH_C);
   assign push     = in_valid && in_ready && !flush;
   assign load     = (count != '0) && (!out_valid || out_ready) && !flush;

   // ---- stage 0: FIFO storage (data only, no reset) ----
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= in_instr;
         pc_mem[wr_ptr]    <= in_pc;
      end
   end

   logic [31:0]     head_instr;
   logic [XLEN-1:0] head_pc;
   logic [6:0]      opc, f7;
   logic [2:0]      f3;

   assign head_instr = instr_mem[rd_ptr];
   assign head_pc    = pc_mem[rd_ptr];
   assign opc        = head_instr[6:0];
   assign f3         = head_instr[14:12];
   assign f7         = head_instr[31:25];

   logic signed [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
   logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j, shamt, shamt_w;
   logic               shl_ok, shr_ok, r_f7_ok;

   assign imm_i32 = {{20{head_instr[31]}}, head_instr[31:20]};
   assign imm_s32 = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
   assign imm_b32 = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                     head_instr[30:25], head_instr[11:8], 1'b0};
   assign imm_u32 = {head_instr[31:12], 12'h000};
   assign imm_j32 = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                     head_instr[20], head_instr[30:21], 1'b0};
   assign imm_i   = XLEN'(imm_i32);
   assign imm_s   = XLEN'(imm_s32);
   assign imm_b   = XLEN'(imm_b32);
   assign imm_u   = XLEN'(imm_u32);
   assign imm_j   = XLEN'(imm_j32);

   // RV64 shift immediates use a 6-bit shamt, which eats funct7[0].
   assign shamt   = (XLEN == 64) ? XLEN'(head_instr[25:20]) : XLEN'(head_instr[24:20]);
   assign shamt_w = XLEN'(head_instr[24:20]);
   assign shl_ok  = (XLEN == 64) ? (head_instr[31:26] == 6'b000000) : (f7 == 7'b0000000);
   assign shr_ok  = (XLEN == 64) ? (head_instr[31:26] == 6'b000000 || head_instr[31:26] == 6'b010000)
                                 : (f7 == 7'b0000000 || f7 == 7'b0100000);
   // funct7 0100000 is only meaningful for ADD->SUB and SRL->SRA.
   assign r_f7_ok = (f7 == 7'b0000000) ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));

   dec_t dec;
   logic dec_ill;

   always_comb begin
      dec     = '0;
      dec_ill = 1'b0;
      case (opc)
         OPC_OP_IMM: begin
            dec.op       = OP_I;
            dec.selb     = 1'b1;
            dec.regwrite = 1'b1;
            dec.imm      = imm_i;
            dec.alufunc  = alu_of_f3(f3);
            if (f3 == 3'b001) begin
               dec.imm = shamt;
               dec_ill = !shl_ok;
            end else if (f3 == 3'b101) begin
               dec.imm = shamt;
               dec_ill = !shr_ok;
               if (head_instr[30]) dec.alufunc = A_SRA;
            end
         end
         OPC_OP: begin
            dec.op       = OP_R;
            dec.regwrite = 1'b1;
            dec.alufunc  = alu_of_f3(f3);
            dec_ill      = !r_f7_ok;
            if (f7[5]) dec.alufunc = (f3 == 3'b000) ? A_SUB : A_SRA;
         end
         OPC_OP_IMMW: begin
            dec.op       = OP_I;
            dec.selb     = 1'b1;
            dec.regwrite = 1'b1;
            dec.wordop   = 1'b1;
            dec.imm      = imm_i;
            dec_ill      = !W_EN;
            case (f3)
               3'b000: dec.alufunc = A_ADD;
               3'b001: begin
                  dec.alufunc = A_SLL;
                  dec.imm     = shamt_w;
                  if (f7 != 7'b0000000) dec_ill = 1'b1;
               end
               3'b101: begin
                  dec.alufunc = head_instr[30] ? A_SRA : A_SRL;
                  dec.imm     = shamt_w;
                  if (f7 != 7'b0000000 && f7 != 7'b0100000) dec_ill = 1'b1;
               end
               default: dec_ill = 1'b1;
            endcase
         end
         OPC_OPW: begin
            dec.op       = OP_R;
            dec.regwrite = 1'b1;
            dec.wordop   = 1'b1;
            dec.alufunc  = alu_of_f3(f3);
            if (f7[5]) dec.alufunc = (f3 == 3'b000) ? A_SUB : A_SRA;
            dec_ill = !W_EN || !r_f7_ok ||
                      !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
         end
         OPC_JAL: begin
            dec.op       = OP_J;
            dec.pcsrc    = 1'b1;
            dec.regwrite = 1'b1;
            dec.wbsel    = 2'd2;
            dec.imm      = imm_j;
         end
         OPC_JALR: begin
            dec.op       = OP_I;
            dec.pctarget = 1'b1;
            dec.pcsrc    = 1'b1;
            dec.regwrite = 1'b1;
            dec.wbsel    = 2'd2;
            dec.selb     = 1'b1;
            dec.imm      = imm_i;
            dec_ill      = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec.op      = OP_B;
            dec.alufunc = A_SUB;
            dec.imm     = imm_b;
            case (f3)
               3'b000:  dec.branch = 3'd1;
               3'b001:  dec.branch = 3'd2;
               3'b100:  dec.branch = 3'd3;
               3'b101:  dec.branch = 3'd4;
               3'b110:  dec.branch = 3'd5;
               3'b111:  dec.branch = 3'd6;
               default: dec_ill    = 1'b1;
            endcase
         end
         OPC_AUIPC: begin
            dec.op       = OP_U;
            dec.alufunc  = A_ADD;
            dec.sela     = 1'b1;
            dec.selb     = 1'b1;
            dec.regwrite = 1'b1;
            dec.imm      = imm_u;
         end
         OPC_LUI: begin
            dec.op       = OP_U;
            dec.wbsel    = 2'd3;
            dec.regwrite = 1'b1;
            dec.imm      = imm_u;
         end
         OPC_LOAD: begin
            dec.op       = OP_I;
            dec.alufunc  = A_ADD;
            dec.selb     = 1'b1;
            dec.regwrite = 1'b1;
            dec.wbsel    = 2'd1;
            dec.memrw    = 2'b01;
            dec.memsize  = f3;
            dec.imm      = imm_i;
            // LD/LWU exist only on RV64; funct3 111 never.
            dec_ill = (f3 == 3'b111) || ((XLEN != 64) && (f3 == 3'b011 || f3 == 3'b110));
         end
         OPC_STORE: begin
            dec.op      = OP_S;
            dec.alufunc = A_ADD;
            dec.selb    = 1'b1;
            dec.memrw   = 2'b10;
            dec.memsize = f3;
            dec.imm     = imm_s;
            dec_ill     = f3[2] || ((XLEN != 64) && (f3 == 3'b011));
         end
         default: dec_ill = 1'b1;
      endcase
      // Illegal instructions travel in order but must not cause side effects.
      if (dec_ill) dec = '0;
      dec.illegal = dec_ill;
   end

   dec_t slot;

   // ---- stage 1: pointers, occupancy and registered output slot ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         slot      <= '0;
         out_pc    <= '0;
         out_rs1   <= '0;
         out_rs2   <= '0;
         out_rd    <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load) rd_ptr <= rd_ptr + 1'b1;
         case ({push, load})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (load) begin
            out_valid <= 1'b1;
            slot      <= dec;
            out_pc    <= head_pc;
            out_rs1   <= head_instr[19:15];
            out_rs2   <= head_instr[24:20];
            out_rd    <= head_instr[11:7];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign out_imm      = slot.imm;
   assign out_op       = slot.op;
   assign out_alufunc  = slot.alufunc;
   assign out_branch   = slot.branch;
   assign out_wbsel    = slot.wbsel;
   assign out_memrw    = slot.memrw;
   assign out_memsize  = slot.memsize;
   assign out_regwrite = slot.regwrite;
   assign out_sela     = slot.sela;
   assign out_selb     = slot.selb;
   assign out_pcsrc    = slot.pcsrc;
   assign out_pctarget = slot.pctarget;
   assign out_wordop   = slot.wordop;
   assign out_illegal  = slot.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: three decode_queue instances (RV64 with W ops, RV64 without,
// RV32) share one stimulus stream and one queue/slot reference model.
module tb_decode_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        o_rdy [3], o_vld [3], o_rw [3], o_sa [3], o_sb [3];
   logic        o_pcs [3], o_pct [3], o_wo [3], o_ill [3];
   logic [63:0] o_pc [3], o_imm [3];
   logic [4:0]  o_rs1 [3], o_rs2 [3], o_rd [3];
   logic [2:0]  o_op [3], o_br [3], o_msz [3];
   logic [3:0]  o_alu [3];
   logic [1:0]  o_wb [3], o_mrw [3];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int XL = (k == 2) ? 32 : 64;
      logic [XL-1:0] pc_w, imm_w;
      decode_queue #(.XLEN(XL), .DEPTH(DEPTH), .ENABLE_W(k != 1)) u_dut (
         .clk(clk), .resetn(resetn), .flush(flush),
         .in_valid(in_valid), .in_ready(o_rdy[k]), .in_instr(in_instr), .in_pc(in_pc[XL-1:0]),
         .out_valid(o_vld[k]), .out_ready(out_ready), .out_pc(pc_w),
         .out_rs1(o_rs1[k]), .out_rs2(o_rs2[k]), .out_rd(o_rd[k]), .out_imm(imm_w),
         .out_op(o_op[k]), .out_alufunc(o_alu[k]), .out_branch(o_br[k]), .out_wbsel(o_wb[k]),
         .out_memrw(o_mrw[k]), .out_memsize(o_msz[k]), .out_regwrite(o_rw[k]),
         .out_sela(o_sa[k]), .out_selb(o_sb[k]), .out_pcsrc(o_pcs[k]),
         .out_pctarget(o_pct[k]), .out_wordop(o_wo[k]), .out_illegal(o_ill[k]));
      assign o_pc[k]  = 64'(pc_w);
      assign o_imm[k] = 64'(imm_w);
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } item_t;

   item_t       fq[$];
   item_t       slot;
   bit          slot_v;
   bit          acc;
   logic [31:0] cur_instr;
   logic [63:0] cur_pc;

   function automatic int xl_of(input int k);
      return (k == 2) ? 32 : 64;
   endfunction

   function automatic logic [63:0] mask_of(input int k);
      return (k == 2) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   // Control word order: op,alu,branch,wbsel,memrw,memsize,rw,sela,selb,pcsrc,pctarget,wordop,illegal
   function automatic void ref_dec(input logic [31:0] i, input int xl, input bit wen_p,
                                   output logic [23:0] ctl, output logic [63:0] imm);
      logic [3:0] alu_tab [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
      logic [2:0] br_tab  [8] = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd3, 3'd4, 3'd5, 3'd6};
      bit         wen = wen_p && (xl == 64);
      logic [2:0] f3 = i[14:12];
      logic [6:0] f7 = i[31:25];
      logic [6:0] hi7 = (xl == 64) ? {i[31:26], 1'b0} : i[31:25];
      logic [63:0] shamt = (xl == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
      longint immi = longint'($signed(i[31:20]));
      longint imms = longint'($signed({i[31:25], i[11:7]}));
      longint immb = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      longint immu = longint'($signed({i[31:12], 12'h000}));
      longint immj = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      logic [2:0] op = 0, br = 0, msz = 0;
      logic [3:0] alu = 0;
      logic [1:0] wb = 0, mrw = 0;
      bit rw = 0, sa = 0, sb = 0, pcs = 0, pct = 0, wo = 0, ok = 1;
      bit f7_r_ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      imm = 64'd0;
      case (i[6:0])
         7'h13: begin
            op = 1; sb = 1; rw = 1; imm = immi; alu = alu_tab[f3];
            if (f3 == 3'd1) begin imm = shamt; ok = (hi7 == 7'h00); end
            if (f3 == 3'd5) begin
               imm = shamt; ok = (hi7 == 7'h00 || hi7 == 7'h20);
               if (i[30]) alu = 4'd7;
            end
         end
         7'h33, 7'h3b: begin
            op = 2; rw = 1; alu = alu_tab[f3]; ok = f7_r_ok;
            if (f7 == 7'h20) alu = (f3 == 3'd0) ? 4'd1 : 4'd7;
            if (i[6:0] == 7'h3b) begin
               wo = 1;
               if (!wen || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ok = 0;
            end
         end
         7'h1b: begin
            op = 1; sb = 1; rw = 1; wo = 1; imm = immi; ok = wen;
            if (f3 == 3'd0) alu = 4'd0;
            else if (f3 == 3'd1) begin alu = 4'd5; imm = 64'(i[24:20]); if (f7 != 0) ok = 0; end
            else if (f3 == 3'd5) begin
               alu = i[30] ? 4'd7 : 4'd6; imm = 64'(i[24:20]);
               if (f7 != 7'h00 && f7 != 7'h20) ok = 0;
            end else ok = 0;
         end
         7'h6f: begin op = 6; pcs = 1; rw = 1; wb = 2; imm = immj; end
         7'h67: begin op = 1; pct = 1; pcs = 1; rw = 1; wb = 2; sb = 1; imm = immi; ok = (f3 == 0); end
         7'h63: begin op = 4; alu = 1; br = br_tab[f3]; imm = immb; ok = (br != 0); end
         7'h17: begin op = 5; sa = 1; sb = 1; rw = 1; imm = immu; end
         7'h37: begin op = 5; wb = 3; rw = 1; imm = immu; end
         7'h03: begin
            op = 1; sb = 1; rw = 1; wb = 1; mrw = 1; msz = f3; imm = immi;
            ok = (f3 != 3'd7) && ((f3 != 3'd3 && f3 != 3'd6) || xl == 64);
         end
         7'h23: begin
            op = 3; sb = 1; mrw = 2; msz = f3; imm = imms;
            ok = (f3 < 3'd3) || (f3 == 3'd3 && xl == 64);
         end
         default: ok = 0;
      endcase
      if (!ok) ctl = 24'd1;
      else ctl = {op, alu, br, wb, mrw, msz, rw, sa, sb, pcs, pct, wo, 1'b0};
      if (!ok) imm = 64'd0;
      if (xl == 32) imm = imm & 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [23:0] ctl_of(input int k);
      return {o_op[k], o_alu[k], o_br[k], o_wb[k], o_mrw[k], o_msz[k], o_rw[k],
              o_sa[k], o_sb[k], o_pcs[k], o_pct[k], o_wo[k], o_ill[k]};
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [6:0]  opcs [11] = '{7'h13, 7'h33, 7'h3b, 7'h1b, 7'h6f, 7'h67,
                                 7'h63, 7'h17, 7'h37, 7'h03, 7'h23};
      logic [31:0] r = $urandom;
      if ($urandom_range(0, 9) == 0) return r;
      r[6:0] = opcs[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1) r[31:25] = {1'b0, r[30], 5'b00000};
      return r;
   endfunction

   task automatic model_step();
      bit push, load;
      if (flush) begin
         fq.delete();
         slot_v = 0;
         acc    = 1;
      end else begin
         push = in_valid && (fq.size() < DEPTH);
         load = (fq.size() > 0) && (!slot_v || out_ready);
         if (load) begin
            slot   = fq.pop_front();
            slot_v = 1;
         end else if (slot_v && out_ready) begin
            slot_v = 0;
         end
         if (push) fq.push_back('{in_instr, in_pc});
         acc = push;
      end
   endtask

   task automatic compare_all();
      logic [23:0] ectl;
      logic [63:0] eimm;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("u%0d.in_ready", k), 64'(o_rdy[k]), 64'(fq.size() < DEPTH));
         chk($sformatf("u%0d.out_valid", k), 64'(o_vld[k]), 64'(slot_v));
         if (slot_v) begin
            ref_dec(slot.instr, xl_of(k), k != 1, ectl, eimm);
            chk($sformatf("u%0d.ctl[%h]", k, slot.instr), 64'(ctl_of(k)), 64'(ectl));
            chk($sformatf("u%0d.imm[%h]", k, slot.instr), o_imm[k], eimm);
            chk($sformatf("u%0d.pc", k), o_pc[k], slot.pc & mask_of(k));
            chk($sformatf("u%0d.regs", k), 64'({o_rs1[k], o_rs2[k], o_rd[k]}),
                64'({slot.instr[19:15], slot.instr[24:20], slot.instr[11:7]}));
         end
      end
   endtask

   // One clock: drive inputs, advance model at the edge, compare at the falling edge.
   task automatic cyc(input bit iv, input bit ordy, input bit fl);
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      in_instr  = cur_instr;
      in_pc     = cur_pc;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (acc) begin
         cur_instr = gen_instr();
         cur_pc    = cur_pc + 64'd4;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 12 && (fq.size() > 0 || slot_v); n++) cyc(1'b0, 1'b1, 1'b0);
   endtask

   // Leaves the given instruction alone in the output slot, held by out_ready=0.
   task automatic dir_load(input logic [31:0] ins, input logic [63:0] pc);
      drain();
      cur_instr = ins;
      cur_pc    = pc;
      cyc(1'b1, 1'b0, 1'b0);
      chk("dir.not_yet_valid", 64'(o_vld[0]), 64'd0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("dir.valid", 64'(o_vld[0]), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      fq.delete(); slot_v = 0; acc = 0;
      cur_instr = gen_instr();
      cur_pc    = 64'h1000;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst.u%0d.in_ready", k), 64'(o_rdy[k]), 64'd0);
         chk($sformatf("rst.u%0d.out_valid", k), 64'(o_vld[k]), 64'd0);
         chk($sformatf("rst.u%0d.ctl", k), 64'(ctl_of(k)), 64'd0);
         chk($sformatf("rst.u%0d.imm", k), o_imm[k], 64'd0);
         chk($sformatf("rst.u%0d.pc", k), o_pc[k], 64'd0);
      end
      resetn = 1'b1;
      @(negedge clk);
      chk("rst.release.in_ready", 64'(o_rdy[0]), 64'd1);

      // addi x1,x0,-1
      dir_load(32'hFFF00093, 64'h100);
      chk("addi.rd", 64'(o_rd[0]), 64'd1);
      chk("addi.imm", o_imm[0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi.imm32", o_imm[2], 64'h0000_0000_FFFF_FFFF);
      chk("addi.op", 64'(o_op[0]), 64'd1);
      chk("addi.alu", 64'(o_alu[0]), 64'd0);
      chk("addi.selb", 64'(o_sb[0]), 64'd1);
      chk("addi.regwrite", 64'(o_rw[0]), 64'd1);
      chk("addi.pc", o_pc[0], 64'h100);

      // Backpressure: fill past capacity, then release.
      for (int n = 0; n < 8; n++) cyc(1'b1, 1'b0, 1'b0);
      chk("full.in_ready", 64'(o_rdy[0]), 64'd0);
      for (int n = 0; n < 8; n++) cyc(1'b0, 1'b1, 1'b0);

      // Steady push+pop with two entries queued behind the slot.
      drain();
      for (int n = 0; n < 3; n++) cyc(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 20; n++) cyc(1'b1, 1'b1, 1'b0);
      chk("steady.in_ready", 64'(o_rdy[0]), 64'd1);

      // Flush while full with a push offered.
      for (int n = 0; n < 6; n++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      chk("flush.out_valid", 64'(o_vld[0]), 64'd0);
      chk("flush.in_ready", 64'(o_rdy[0]), 64'd1);
      for (int n = 0; n < 6; n++) cyc(1'b1, 1'b1, 1'b0);

      // bgeu x1,x2,-4
      dir_load(32'hFE20FEE3, 64'h200);
      chk("bgeu.op", 64'(o_op[0]), 64'd4);
      chk("bgeu.branch", 64'(o_br[0]), 64'd6);
      chk("bgeu.alu", 64'(o_alu[0]), 64'd1);
      chk("bgeu.imm", o_imm[0], 64'hFFFF_FFFF_FFFF_FFFC);

      dir_load(32'hFFFFFFFF, 64'h204);
      chk("ones.illegal", 64'(o_ill[0]), 64'd1);
      chk("ones.regwrite", 64'(o_rw[0]), 64'd0);

      // addiw x5,x5,1
      dir_load(32'h0012829B, 64'h208);
      chk("addiw.wordop", 64'(o_wo[0]), 64'd1);
      chk("addiw.alu", 64'(o_alu[0]), 64'd0);
      chk("addiw.illegal", 64'(o_ill[0]), 64'd0);
      chk("addiw.noW.illegal", 64'(o_ill[1]), 64'd1);
      chk("addiw.rv32.illegal", 64'(o_ill[2]), 64'd1);

      // Randomized traffic with occasional flushes.
      for (int n = 0; n < 1500; n++)
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);

      // Asynchronous reset between clock edges.
      for (int n = 0; n < 4; n++) cyc(1'b1, 1'b0, 1'b0);
      #2 resetn = 1'b0;
      #1;
      chk("arst.out_valid", 64'(o_vld[0]), 64'd0);
      chk("arst.in_ready", 64'(o_rdy[0]), 64'd0);
      chk("arst.pc", o_pc[0], 64'd0);
      fq.delete();
      slot_v = 0;
      @(negedge clk);
      resetn = 1'b1;
      for (int n = 0; n < 30; n++) cyc($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-cycle RV decoder.
- Buffers fetched instructions in a DEPTH-entry FIFO between fetch and execute.
- Decodes the FIFO head into control fields plus an XLEN-wide immediate, and presents them through a registered valid/ready output slot.
- Adds full RV base ALU/branch coverage, optional RV64 word ops, illegal-instruction flagging, and pipeline flush.

Parameters:
XLEN, 64, datapath/immediate/PC width (32 or 64)
DEPTH, 4, FIFO entries; power of two, >=2
ENABLE_W, 1, decode OP-IMM-32 (0011011)/OP-32 (0111011); forced off when XLEN=32

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of FIFO and output slot
in_valid  in  1  fetch offers instruction
in_ready  out  1  queue can accept
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded slot valid
out_ready  in  1  execute accepts slot
out_pc  out  XLEN  PC of decoded instr
out_rs1/out_rs2/out_rd  out  5 each  register indices
out_imm  out  XLEN  sign-extended immediate (U-type: imm<<12, sign-extended)
out_op  out  3  1 ITYPE,2 RTYPE,3 STYPE,4 BTYPE,5 UTYPE,6 JTYPE,0 none
out_alufunc  out  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
out_branch  out  3  0 none,1 BEQ,2 BNE,3 BLT,4 BGE,5 BLTU,6 BGEU
out_wbsel  out  2  0 ALU,1 MEM,2 PC+4,3 IMM
out_memrw  out  2  01 read,10 write,00 none
out_memsize  out  3  funct3 of load/store
out_regwrite/out_sela/out_selb/out_pcsrc/out_pctarget/out_wordop/out_illegal  out  1 each  control flags

Behaviour:
- Reset (resetn low, asynchronous): pointers and count=0; all out_* = 0; in_ready=0 while resetn low, then count<DEPTH.
- in_ready = (count<DEPTH) combinationally; no pass-through push when full.
- Push at edge when in_valid&&in_ready&&!flush; entry stores {instr,pc}.
- Output slot loads decoded head at edge when count>0 && (!out_valid || out_ready) && !flush; that entry pops.
- Push and pop at the same edge: count unchanged.
- out_valid drops when out_ready&&out_valid and nothing loads.
- Latency: instruction pushed at edge k is on out_* with out_valid=1 after edge k+1 at earliest.
- Output fields are stable while out_valid&&!out_ready.
- flush: next edge count=0, out_valid=0, pointers reset; a push in that cycle is dropped; flush overrides all other events.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Decode per opcode:
  - OP-IMM: selb, regwrite; f3 000 ADD, 100 XOR, 110 OR, 111 AND, 010 SLT, 011 SLTU, 001 SLL, 101 SRL/SRA by instr[30]. Shamt is instr[25:20] for XLEN=64, instr[24:20] for XLEN=32.
  - OP: add/sub etc. by f3 plus funct7 (0000000 or 0100000 only).
  - JAL: JTYPE, pcsrc, regwrite, wbsel=2.
  - JALR: ITYPE, pctarget, pcsrc, regwrite, wbsel=2, selb.
  - BRANCH: SUB, branch by f3; 010/011 illegal.
  - AUIPC: ADD, sela, selb, regwrite.
  - LUI: wbsel=3, regwrite.
  - LOAD: ADD, selb, regwrite, wbsel=1, memrw=01.
  - STORE: STYPE, ADD, selb, memrw=10.
  - W ops (ENABLE_W): as OP-IMM/OP with wordop=1; only ADD/SUB/SLL/SRL/SRA legal.
- Illegal instruction: unknown opcode, f3 or funct7 gives illegal=1 with regwrite, memrw, pcsrc, branch all 0; it is still delivered in order.
- Immediates: I/S/B/U/J per RV spec, sign-extended to XLEN.

Test Plan:
- Reset, then push addi x1,x0,-1 (0xFFF00093, pc=0x100) -> 2 edges later out_valid=1, rd=1, imm=all ones, op=1, alufunc=0, selb=1, regwrite=1.
- Hold out_ready=0, push DEPTH+1 instrs -> in_ready=0 after DEPTH pushes; outputs stable; release yields them in order with correct pcs.
- Push and pop every cycle for 20 cycles with count=2 -> count stays 2, no loss, no duplication.
- flush asserted with queue full while in_valid=1 -> next cycle out_valid=0, in_ready=1, flush-cycle instr never appears.
- bgeu x1,x2,-4 (0xFE20FEE3) -> op=4, branch=6, alufunc=1, imm=-4; 0xFFFFFFFF -> illegal=1, regwrite=0.
- XLEN=64: addiw x5,x5,1 (0x0012829B) -> wordop=1, alufunc=0; with ENABLE_W=0 -> illegal=1.
